// File: rtl/user_rw_test_sequencer.sv
// Sequencer for the AXI4 read/write loopback test: per loop it triggers a write package,
// then a read package, and checks the returned beats against an incrementing pattern.
module user_rw_test_sequencer #(
  parameter int USER_DATA_WIDTH = 16,
  parameter int PACKAGE_LEN     = 1024,
  parameter int LOOP_W          = 8,
  parameter int ERR_W           = 16,
  parameter int TIMEOUT_CYC     = 65535
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [LOOP_W-1:0]          loop_num,
  output logic                       wr_trig,
  input  logic                       wr_done,
  output logic                       rd_trig,
  input  logic                       rd_data_vld,
  input  logic [USER_DATA_WIDTH-1:0] rd_data,
  input  logic                       rd_done,
  output logic                       busy,
  output logic                       test_done,
  output logic                       test_pass,
  output logic                       timeout,
  output logic [ERR_W-1:0]           err_cnt,
  output logic [LOOP_W-1:0]          loop_cnt
);

  localparam int BEAT_W = $clog2(PACKAGE_LEN + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(PACKAGE_LEN);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, WR_TRIG, WR_WAIT, RD_TRIG, RD_WAIT, CHECK, DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [LOOP_W-1:0]          loops_q, loops_d;
  logic [LOOP_W-1:0]          loop_cnt_q, loop_cnt_d;
  logic [ERR_W-1:0]           err_q, err_d, err_chk;
  logic                       timeout_q, timeout_d;
  logic                       pass_q, pass_d;
  logic [USER_DATA_WIDTH-1:0] exp_q, exp_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [TMR_W-1:0]           timer_q, timer_d;

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [BEAT_W-1:0] beat_sat_inc(input logic [BEAT_W-1:0] v);
    return (&v) ? v : v + BEAT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    loops_d    = loops_q;
    loop_cnt_d = loop_cnt_q;
    err_d      = err_q;
    err_chk    = err_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    exp_d      = exp_q;
    beat_d     = beat_q;
    timer_d    = timer_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          loops_d    = (loop_num == '0) ? LOOP_W'(1) : loop_num;
          loop_cnt_d = '0;
          err_d      = '0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
          state_d    = WR_TRIG;
        end
      end
      WR_TRIG: begin
        timer_d = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (wr_done) begin
          state_d = RD_TRIG;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RD_TRIG: begin
        exp_d   = '0;
        beat_d  = '0;
        timer_d = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // A beat arriving together with rd_done is still counted and compared.
        if (rd_data_vld) begin
          if (rd_data != exp_q) err_d = err_sat_inc(err_q);
          exp_d   = exp_q + USER_DATA_WIDTH'(1);
          beat_d  = beat_sat_inc(beat_q);
          timer_d = '0;
        end
        if (rd_done) begin
          state_d = CHECK;
        end else if (!rd_data_vld) begin
          if (timer_q == TMR_LAST) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      CHECK: begin
        err_chk    = (beat_q != BEAT_FULL) ? err_sat_inc(err_q) : err_q;
        err_d      = err_chk;
        loop_cnt_d = loop_cnt_q + LOOP_W'(1);
        if (loop_cnt_d == loops_q) begin
          // Only a completed run can pass; timeout is necessarily clear here.
          pass_d  = (err_chk == '0);
          state_d = DONE;
        end else begin
          state_d = WR_TRIG;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      loops_q    <= '0;
      loop_cnt_q <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      exp_q      <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      loops_q    <= loops_d;
      loop_cnt_q <= loop_cnt_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
      exp_q      <= exp_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
    end
  end

  assign wr_trig   = (state_q == WR_TRIG);
  assign rd_trig   = (state_q == RD_TRIG);
  assign busy      = (state_q != IDLE);
  assign test_done = (state_q == DONE);
  assign test_pass = pass_q;
  assign timeout   = timeout_q;
  assign err_cnt   = err_q;
  assign loop_cnt  = loop_cnt_q;

endmodule

// File: tb/tb_user_rw_test_sequencer.sv
// Directed, table-driven bench for user_rw_test_sequencer with a small write/read responder.
module tb_user_rw_test_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  loop_num;
  logic        wr_trig;
  logic        wr_done;
  logic        rd_trig;
  logic        rd_data_vld;
  logic [15:0] rd_data;
  logic        rd_done;
  logic        busy;
  logic        test_done;
  logic        test_pass;
  logic        timeout;
  logic [15:0] err_cnt;
  logic [7:0]  loop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  user_rw_test_sequencer #(
    .USER_DATA_WIDTH(16),
    .PACKAGE_LEN    (1024),
    .LOOP_W         (8),
    .ERR_W          (16),
    .TIMEOUT_CYC    (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .loop_num   (loop_num),
    .wr_trig    (wr_trig),
    .wr_done    (wr_done),
    .rd_trig    (rd_trig),
    .rd_data_vld(rd_data_vld),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .busy       (busy),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .timeout    (timeout),
    .err_cnt    (err_cnt),
    .loop_cnt   (loop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  ln;
    int          nbeats;
    int          bad_idx;
    logic [15:0] bad_val;
    bit          same;
    bit          no_wr;
    bit          start_busy;
    int          e_wr;
    int          e_rd;
    int          e_err;
    int          e_loop;
    int          e_pass;
    int          e_to;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_trig"},   32'(wr_trig),   0);
    chk({tag, "_rd_trig"},   32'(rd_trig),   0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_test_done"}, 32'(test_done), 0);
    chk({tag, "_test_pass"}, 32'(test_pass), 0);
    chk({tag, "_timeout"},   32'(timeout),   0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   0);
    chk({tag, "_loop_cnt"},  32'(loop_cnt),  0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  wr_n, rd_n, t0, wr_cyc;
    bit  fin;
    string tag;
    tag = $sformatf("v%0d", id);
    wr_n = 0; rd_n = 0; fin = 0; wr_cyc = 0;
    start = 1'b1; loop_num = v.ln;
    tick;
    start = 1'b0;
    t0 = cyc;
    chk({tag, "_busy_rise"},    32'(busy),    1);
    chk({tag, "_start_to_wr"},  32'(wr_trig), 1);
    while (!fin) begin
      if (cyc - t0 > 20000) begin
        checks++; errors++;
        $display("FAIL %s_budget got no test_done expected test_done within 20000 cycles", tag);
        fin = 1;
      end else if (test_done) begin
        fin = 1;
      end else if (wr_trig) begin
        wr_n++;
        wr_cyc = cyc;
        if (!v.no_wr) begin
          for (int k = 0; k < 4; k++) begin
            if (v.start_busy && k == 1) begin
              start = 1'b1; loop_num = 8'd5;
            end
            tick;
            start = 1'b0;
          end
          wr_done = 1'b1;
          tick;
          wr_done = 1'b0;
          chk({tag, "_wrdone_to_rd"}, 32'(rd_trig), 1);
        end else begin
          tick;
        end
      end else if (rd_trig) begin
        rd_n++;
        tick;
        for (int i = 0; i < v.nbeats; i++) begin
          rd_data_vld = 1'b1;
          rd_data = (i == v.bad_idx) ? v.bad_val : 16'(i);
          if (v.same && i == v.nbeats - 1) rd_done = 1'b1;
          tick;
        end
        rd_data_vld = 1'b0;
        if (!v.same) begin
          rd_done = 1'b1;
          tick;
        end
        rd_done = 1'b0;
        chk({tag, "_check_no_wr"}, 32'(wr_trig), 0);
      end else begin
        tick;
      end
    end
    if (v.no_wr) chk({tag, "_to_latency"}, 32'(cyc - wr_cyc), 17);
    chk({tag, "_wr_pairs"},  32'(wr_n),      32'(v.e_wr));
    chk({tag, "_rd_pairs"},  32'(rd_n),      32'(v.e_rd));
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'(v.e_err));
    chk({tag, "_loop_cnt"},  32'(loop_cnt),  32'(v.e_loop));
    chk({tag, "_test_pass"}, 32'(test_pass), 32'(v.e_pass));
    chk({tag, "_timeout"},   32'(timeout),   32'(v.e_to));
    chk({tag, "_busy_done"}, 32'(busy),      1);
    tick;
    chk({tag, "_busy_fall"}, 32'(busy),      0);
    chk({tag, "_done_once"}, 32'(test_done), 0);
    chk({tag, "_pass_held"}, 32'(test_pass), 32'(v.e_pass));
    tick;
    tick;
    chk({tag, "_idle_no_wr"}, 32'(wr_trig), 0);
    chk({tag, "_idle_busy"},  32'(busy),    0);
  endtask

  initial begin
    //          ln     nb    bad  bval      same nowr sb  wr rd err loop pass to
    vecs[0] = '{8'd1, 1024, -1,  16'h0000, 0,   0,   0,  1, 1, 0,  1,   1,   0};
    vecs[1] = '{8'd1, 1024, 100, 16'hFFFF, 0,   0,   0,  1, 1, 1,  1,   0,   0};
    vecs[2] = '{8'd1, 1023, -1,  16'h0000, 0,   0,   0,  1, 1, 1,  1,   0,   0};
    vecs[3] = '{8'd3, 1024, -1,  16'h0000, 1,   0,   0,  3, 3, 0,  3,   1,   0};
    vecs[4] = '{8'd0, 1024, -1,  16'h0000, 0,   0,   0,  1, 1, 0,  1,   1,   0};
    vecs[5] = '{8'd2, 1024, -1,  16'h0000, 0,   1,   0,  1, 0, 0,  0,   0,   1};
    vecs[6] = '{8'd2, 1025, -1,  16'h0000, 0,   0,   0,  2, 2, 2,  2,   0,   0};
    vecs[7] = '{8'd1, 1024, -1,  16'h0000, 1,   0,   1,  1, 1, 0,  1,   1,   0};

    resetn = 1'b0; start = 1'b0; loop_num = 8'd0; wr_done = 1'b0;
    rd_data_vld = 1'b0; rd_data = 16'd0; rd_done = 1'b0;
    repeat (3) tick;
    chk_zero("reset");
    resetn = 1'b1;
    tick;

    // Stray handshakes while idle must not disturb anything.
    wr_done = 1'b1; rd_data_vld = 1'b1; rd_done = 1'b1; rd_data = 16'h0007;
    repeat (3) tick;
    wr_done = 1'b0; rd_data_vld = 1'b0; rd_done = 1'b0;
    chk_zero("stray");

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a read package.
    start = 1'b1; loop_num = 8'd1;
    tick;
    start = 1'b0;
    tick;
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    chk("mid_rd_trig", 32'(rd_trig), 1);
    tick;
    for (int i = 0; i < 10; i++) begin
      rd_data_vld = 1'b1;
      rd_data = (i == 3) ? 16'hAAAA : 16'(i);
      tick;
    end
    rd_data_vld = 1'b0;
    chk("mid_err_cnt", 32'(err_cnt), 1);
    chk("mid_busy", 32'(busy), 1);
    #2 resetn = 1'b0;
    #1 chk_zero("async_rst");
    tick;
    tick;
    resetn = 1'b1;
    tick;
    chk("rel1_wr_trig", 32'(wr_trig), 0);
    chk("rel1_rd_trig", 32'(rd_trig), 0);
    chk("rel1_busy",    32'(busy),    0);
    tick;
    chk("rel2_wr_trig", 32'(wr_trig), 0);
    chk("rel2_rd_trig", 32'(rd_trig), 0);
    run_vec(8, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
